// File: rtl/vsign_ctx_queue_pkg.sv
// Shared definitions for the vector FMA sign-context queue: rounding-mode
// encodings and the bit layout of one lane's queued context.
package vsign_ctx_queue_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // Per-lane context field offsets
  localparam int unsigned S_TMP   = 0;
  localparam int unsigned FINAL_M = 1;
  localparam int unsigned EN      = 2;
  localparam int unsigned CTX_W   = 3;

endpackage

// File: rtl/vsign_lane_resolve.sv
// Resolves one lane's final FMA sign from its queued context and the
// magnitude information returned by the mantissa datapath.
module vsign_lane_resolve (
  input  logic s_tmp,
  input  logic final_m,
  input  logic en,
  input  logic diff_neg,
  input  logic zero,
  input  logic rdn,
  output logic sign
);

  always_comb begin
    sign = 1'b0;
    if (!en) begin
      sign = 1'b0;
    end else if (final_m) begin
      sign = s_tmp;
    end else if (zero) begin
      // Exact cancellation: -0 only when rounding down
      sign = rdn;
    end else begin
      sign = s_tmp ^ diff_neg;
    end
  end

endmodule

// File: rtl/vsign_ctx_queue.sv
// Vector FMA sign handler: computes sign context at issue, holds it in order
// until the datapath returns magnitude info, then emits the resolved sign.
module vsign_ctx_queue
  import vsign_ctx_queue_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned RM_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_sa,
  input  logic [LANES-1:0]         in_sb,
  input  logic [LANES-1:0]         in_sc,
  input  logic [LANES-1:0]         in_lane_en,
  input  logic                     in_neg_prod,
  input  logic                     in_neg_add,
  input  logic [RM_W-1:0]          in_rm,
  output logic [LANES-1:0]         issue_eff_sub,
  input  logic                     res_valid,
  input  logic [LANES-1:0]         res_diff_neg,
  input  logic [LANES-1:0]         res_zero,
  output logic                     sign_valid,
  output logic [LANES-1:0]         sign_out,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     underflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [LANES-1:0] prod_sign, add_sign, eff_sub;
  logic [LANES-1:0][CTX_W-1:0] wr_ctx, rd_ctx;
  logic [LANES-1:0][CTX_W-1:0] ctx_mem [DEPTH];
  logic [RM_W-1:0]             rm_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] q_count_q, q_count_d;
  logic             sign_valid_q, underflow_q;
  logic [LANES-1:0] sign_out_q, resolved;
  logic             push, pop, rd_rdn;

  assign prod_sign     = in_sa ^ in_sb ^ {LANES{in_neg_prod}};
  assign add_sign      = in_sc ^ {LANES{in_neg_add}};
  assign eff_sub       = prod_sign ^ add_sign;
  assign issue_eff_sub = eff_sub & in_lane_en;

  always_comb begin
    wr_ctx = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_ctx[i][S_TMP]   = prod_sign[i];
      wr_ctx[i][FINAL_M] = ~eff_sub[i];
      wr_ctx[i][EN]      = in_lane_en[i];
    end
  end

  // An empty queue never pops, even if a push lands in the same cycle
  assign pop      = res_valid & (q_count_q != '0);
  assign in_ready = (q_count_q < DEPTH_CNT) | pop;
  assign push     = in_valid & in_ready;

  always_comb begin
    q_count_d = q_count_q;
    case ({push, pop})
      2'b10:   q_count_d = q_count_q + 1'b1;
      2'b01:   q_count_d = q_count_q - 1'b1;
      default: q_count_d = q_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ctx_mem[wr_ptr_q] <= wr_ctx;
      rm_mem[wr_ptr_q]  <= in_rm;
    end
  end

  assign rd_ctx = ctx_mem[rd_ptr_q];
  assign rd_rdn = (rm_mem[rd_ptr_q] == RM_W'(RM_RDN));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vsign_lane_resolve u_resolve (
      .s_tmp   (rd_ctx[g][S_TMP]),
      .final_m (rd_ctx[g][FINAL_M]),
      .en      (rd_ctx[g][EN]),
      .diff_neg(res_diff_neg[g]),
      .zero    (res_zero[g]),
      .rdn     (rd_rdn),
      .sign    (resolved[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      q_count_q    <= '0;
      sign_valid_q <= 1'b0;
      sign_out_q   <= '0;
      underflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        sign_out_q <= resolved;
      end
      q_count_q    <= q_count_d;
      sign_valid_q <= pop;
      if (res_valid && (q_count_q == '0)) underflow_q <= 1'b1;
    end
  end

  assign sign_valid    = sign_valid_q;
  assign sign_out      = sign_out_q;
  assign q_count       = q_count_q;
  assign underflow_err = underflow_q;

endmodule
